// File: rtl/instr_decode.sv
// rtl/instr_decode.sv - decode/issue stage: register file, busy scoreboard, zero-overhead loop; optional ID_BYPASS_EN
// ID_BYPASS_EN: forward a same-cycle writeback to the source operands instead of stalling.
module instr_decode #(
    parameter int LCW = 16
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic [31:0] id_instr,
    input  logic [15:0] id_pc,
    input  logic        ex_stall,
    input  logic        wb_en,
    input  logic [3:0]  wb_rd,
    input  logic [31:0] wb_data,
    output logic        Stall,
    output logic        Loop,
    output logic [15:0] PC_in,
    output logic        ex_valid,
    output logic [3:0]  ex_op,
    output logic [3:0]  ex_rd,
    output logic [31:0] ex_a,
    output logic [31:0] ex_b,
    output logic [15:0] ex_imm,
    output logic [15:0] ex_pc,
    output logic        illegal
);
    localparam logic [3:0] OP_NOP     = 4'd0;
    localparam logic [3:0] OP_ADD     = 4'd1;
    localparam logic [3:0] OP_SUB     = 4'd2;
    localparam logic [3:0] OP_ADDI    = 4'd3;
    localparam logic [3:0] OP_LD      = 4'd4;
    localparam logic [3:0] OP_ST      = 4'd5;
    localparam logic [3:0] OP_LOOPSET = 4'd6;
    localparam logic [3:0] OP_LOOP    = 4'd7;

    logic [3:0]  op, rd, rs, rt;
    logic [15:0] imm;

    assign op  = id_instr[31:28];
    assign rd  = id_instr[27:24];
    assign rs  = id_instr[23:20];
    assign rt  = id_instr[19:16];
    assign imm = id_instr[15:0];

    logic [31:0]    regs [16];
    logic [15:0]    busy, busy_next;
    logic [LCW-1:0] lcnt;
    logic           squash;

    logic uses_rs, uses_rt, writes_rd, issues, is_illegal, b_is_imm;
    logic wb_hit_rs, wb_hit_rt, rs_blocked, rt_blocked;
    logic hazard, fire, take;
    logic [31:0] rs_val, rt_val, b_val;

    always_comb begin
        uses_rs    = 1'b0;
        uses_rt    = 1'b0;
        writes_rd  = 1'b0;
        issues     = 1'b0;
        is_illegal = 1'b0;
        case (op)
            OP_ADD, OP_SUB: begin
                uses_rs = 1'b1; uses_rt = 1'b1; writes_rd = 1'b1; issues = 1'b1;
            end
            OP_ADDI, OP_LD: begin
                uses_rs = 1'b1; writes_rd = 1'b1; issues = 1'b1;
            end
            OP_ST: begin
                uses_rs = 1'b1; uses_rt = 1'b1; issues = 1'b1;
            end
            OP_NOP, OP_LOOPSET, OP_LOOP: ;
            default: is_illegal = 1'b1;
        endcase
    end

    assign b_is_imm  = (op == OP_ADDI) || (op == OP_LD);
    assign wb_hit_rs = wb_en && (wb_rd == rs) && (rs != 4'd0);
    assign wb_hit_rt = wb_en && (wb_rd == rt) && (rt != 4'd0);

`ifdef ID_BYPASS_EN
    assign rs_blocked = busy[rs] && !wb_hit_rs;
    assign rt_blocked = busy[rt] && !wb_hit_rt;
    assign rs_val     = wb_hit_rs ? wb_data : regs[rs];
    assign rt_val     = wb_hit_rt ? wb_data : regs[rt];
`else
    // A value landing this cycle is not yet in regs; wait one cycle and read it from there.
    assign rs_blocked = busy[rs] || wb_hit_rs;
    assign rt_blocked = busy[rt] || wb_hit_rt;
    assign rs_val     = regs[rs];
    assign rt_val     = regs[rt];
`endif

    // A squashed slot is discarded, so its operands can never hold up fetch.
    assign hazard = !squash && ((uses_rs && rs_blocked) || (uses_rt && rt_blocked));
    assign Stall  = hazard || ex_stall;
    assign fire   = !Stall;
    assign take   = fire && !squash;
    assign Loop   = take && (op == OP_LOOP) && (lcnt != '0);
    assign PC_in  = imm;
    assign b_val  = b_is_imm ? {16'h0000, imm} : rt_val;

    always_comb begin
        busy_next = busy;
        if (wb_en)
            busy_next[wb_rd] = 1'b0;
        if (take && writes_rd && (rd != 4'd0))
            busy_next[rd] = 1'b1;
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 16; i++)
                regs[i] <= '0;
            busy     <= '0;
            lcnt     <= '0;
            squash   <= 1'b0;
            illegal  <= 1'b0;
            ex_valid <= 1'b0;
            ex_op    <= '0;
            ex_rd    <= '0;
            ex_a     <= '0;
            ex_b     <= '0;
            ex_imm   <= '0;
            ex_pc    <= '0;
        end else begin
            if (wb_en && (wb_rd != 4'd0))
                regs[wb_rd] <= wb_data;
            busy    <= busy_next;
            illegal <= take && is_illegal;
            if (fire)
                squash <= Loop;
            if (take && (op == OP_LOOPSET))
                lcnt <= LCW'(imm);
            else if (Loop)
                lcnt <= lcnt - LCW'(1);
            if (!ex_stall) begin
                if (take && issues) begin
                    ex_valid <= 1'b1;
                    ex_op    <= op;
                    ex_rd    <= rd;
                    ex_a     <= rs_val;
                    ex_b     <= b_val;
                    ex_imm   <= imm;
                    ex_pc    <= id_pc;
                end else begin
                    ex_valid <= 1'b0;
                    ex_op    <= '0;
                    ex_rd    <= '0;
                    ex_a     <= '0;
                    ex_b     <= '0;
                    ex_imm   <= '0;
                    ex_pc    <= '0;
                end
            end
        end
    end
endmodule

// File: doc/instr_decode.md
INSTR_DECODE -- requirements
Module: instr_decode

Interface
REQ-001 The block SHALL have parameter LCW, default 16: loop-counter width in bits.
REQ-002 The block SHALL have port CLOCK_50  input  1  system clock, all state on rising edge.
REQ-003 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 The block SHALL have port id_instr  input  32  instruction word from fetch.
REQ-005 The block SHALL have port id_pc  input  16  PC of id_instr, from fetch.
REQ-006 The block SHALL have port ex_stall  input  1  execute stage cannot accept this cycle.
REQ-007 The block SHALL have port wb_en  input  1  writeback strobe.
REQ-008 The block SHALL have port wb_rd  input  4  writeback register index.
REQ-009 The block SHALL have port wb_data  input  32  writeback data.
REQ-010 The block SHALL have port Stall  output  1  hold fetch.
REQ-011 The block SHALL have port Loop  output  1  redirect fetch to PC_in.
REQ-012 The block SHALL have port PC_in  output  16  redirect target.
REQ-013 The block SHALL have registered execute outputs: ex_valid 1, ex_op 4, ex_rd 4, ex_a 32, ex_b 32, ex_imm 16, ex_pc 16.
REQ-014 The block SHALL have port illegal  output  1  registered one-cycle pulse on an undefined opcode.

Function
REQ-015 The block SHALL decode id_instr as: op [31:28], rd [27:24], rs [23:20], rt [19:16], imm [15:0].
REQ-016 The opcode map SHALL be: 0 NOP, 1 ADD, 2 SUB, 3 ADDI, 4 LD, 5 ST, 6 LOOPSET, 7 LOOP, 8-15 illegal (issued as NOP, illegal=1).
REQ-017 The block SHALL hold a 16x32 register file; r0 SHALL read 0 and ignore writes.
REQ-018 The block SHALL hold a 16-bit busy scoreboard:
- ADD/SUB/ADDI/LD issue with rd!=0 sets busy[rd];
- wb_en clears busy[wb_rd];
- set and clear of the same bit in the same cycle SHALL leave the bit set.
REQ-019 hazard SHALL be 1 when a source of the current instruction is busy: rs for ADD/SUB/ADDI/LD/ST; rt for ADD/SUB/ST.
REQ-020 Stall SHALL equal hazard OR ex_stall (combinational).
REQ-021 When ex_stall=1, all ex_* outputs SHALL hold their values.
REQ-022 When hazard=1 and ex_stall=0, the block SHALL issue a bubble (ex_valid=0).
REQ-023 Otherwise the block SHALL issue on the next edge with 1-cycle latency:
- ex_valid=1;
- ex_a=reg[rs];
- ex_b=reg[rt] (ST/ADD/SUB), or zero-extended imm (ADDI/LD);
- ex_op, ex_rd, ex_imm, ex_pc registered from the decoded instruction.
REQ-024 LOOPSET SHALL load lcnt (LCW bits) with imm[LCW-1:0] and issue a bubble.
REQ-025 LOOP with lcnt!=0 and ex_stall=0 SHALL:
- assert Loop=1 with PC_in=imm combinationally;
- decrement lcnt;
- set the squash flag.
REQ-026 LOOP with lcnt==0 SHALL fall through with Loop=0 and no lcnt change.
REQ-027 Behaviour of LOOP and LOOPSET over a loop:
- LOOPSET N followed by a LOOP back-edge SHALL execute the body N+1 times;
- LOOP SHALL issue a bubble.
REQ-028 When squash=1, the next non-stalled id_instr SHALL be discarded (bubble, no scoreboard or lcnt effect), and squash SHALL clear.
REQ-029 Loop SHALL never be asserted while Stall=1.
REQ-030 A register-file write SHALL occur on the edge when wb_en=1.

Reset
REQ-031 On reset, asynchronously and independent of the clock, the block SHALL clear:
- registers, busy, lcnt and squash to 0;
- all ex_* outputs and illegal to 0.
REQ-032 Reset asserted mid-loop SHALL abandon the loop; Loop=0 after reset.

Configuration
REQ-033 With ID_BYPASS_EN defined, a same-cycle wb_en to a source register SHALL:
- be treated as not busy;
- forward wb_data to ex_a or ex_b.
REQ-034 Without ID_BYPASS_EN, that case SHALL stall one cycle and the value SHALL be read from the register file next cycle.

Verification
REQ-035 Reset, then ADD r1,r0,r0 -> ex_valid=1 next cycle, ex_a=0, ex_b=0, busy[1]=1.
REQ-036 ADD r2,r1,r1 while busy[1]; wb_en r1=0x5 three cycles later -> Stall=1 for those three cycles, then ex_a=ex_b=5.
REQ-037 LOOPSET 2; body at PC 4; LOOP imm=4 -> Loop=1 with PC_in=4 twice; the wrong-path instruction is squashed each time; third LOOP falls through; body executes 3 times.
REQ-038 ex_stall held for 2 cycles -> ex_* outputs unchanged; Stall=1; no Loop.
REQ-039 Opcode 0xF -> illegal pulses 1 cycle; ex_valid=0.
REQ-040 With ID_BYPASS_EN, ADD r3,r1,r0 with wb r1=0xA same cycle -> no stall, ex_a=0xA; without the macro -> 1 stall cycle, then ex_a=0xA.
